// File: rtl/siso_pkg.sv
// Shared types and helpers for the serial transmit controller.
// SISO_TX_PARITY_EN appends an even-parity bit period after the data bits.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef SISO_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/siso_tx_ctrl_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while running.
// first is a registered strobe marking the opening cycle of each period.
module bit_timer
    import siso_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic more,
    output logic wrap,
    output logic first
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign wrap = run && (cnt == TOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (run) begin
            cnt   <= wrap ? '0 : cnt + CW'(1);
            // a new period opens only if another bit follows
            first <= wrap & more;
        end else begin
            cnt   <= '0;
            first <= 1'b0;
        end
    end

endmodule

// File: rtl/siso_tx_ctrl.sv
// Parallel-to-serial transmit sequencer with per-bit strobe and done pulse.
// Optional macro SISO_TX_PARITY_EN adds a trailing even-parity bit period.
module siso_tx_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    localparam int NB = WIDTH + PAR_BITS;
    localparam int BW = cnt_w(NB);
    localparam logic [BW-1:0] LAST = BW'(NB - 1);
    localparam bit MSB = (MSB_FIRST != 0);

    state_t        state;
    logic [NB-1:0] sreg;
    logic [NB-1:0] load;
    logic [NB-1:0] shifted;
    logic [BW-1:0] bcnt;
    logic          accept;
    logic          last;
    logic          wrap;
    logic          first_bit;
    logic          next_bit;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (bcnt == LAST);

    always_comb begin
`ifdef SISO_TX_PARITY_EN
        // parity sits where the shift reaches it after the data bits
        load = MSB ? {in_data, ^in_data} : {^in_data, in_data};
`else
        load = in_data;
`endif
        first_bit = MSB ? in_data[WIDTH-1] : in_data[0];
        next_bit  = MSB ? sreg[NB-2] : sreg[1];
        shifted   = MSB ? {sreg[NB-2:0], 1'b0} : {1'b0, sreg[NB-1:1]};
    end

    bit_timer #(
        .DIV(DIV)
    ) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .run  (state == SHIFT),
        .more (!last),
        .wrap (wrap),
        .first(bit_stb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bcnt     <= '0;
            sout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        sreg     <= load;
                        bcnt     <= '0;
                        sout     <= first_bit;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (wrap) begin
                        if (last) begin
                            sout  <= 1'b0;
                            done  <= 1'b1;
                            sreg  <= '0;
                            state <= DONE;
                        end else begin
                            sreg <= shifted;
                            bcnt <= bcnt + BW'(1);
                            sout <= next_bit;
                        end
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    bcnt     <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Randomized checking bench for siso_tx_ctrl against a per-cycle timing model.
// Two instances: (WIDTH 8, DIV 4, LSB first) and (WIDTH 8, DIV 1, MSB first).
module tb_siso_tx_ctrl;

`ifdef SISO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk;
    logic       rst;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       r0, s0, t0, b0, n0;
    logic       r1, s1, t1, b1, n1;

    int tests;
    int fails;

    siso_tx_ctrl #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0),
        .in_ready(r0), .sout(s0), .bit_stb(t0), .busy(b0), .done(n0)
    );

    siso_tx_ctrl #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
        .in_ready(r1), .sout(s1), .bit_stb(t1), .busy(b1), .done(n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sout, bit_stb, busy, done, in_ready}
    function automatic logic [4:0] obs(input int sel);
        return (sel == 0) ? {s0, t0, b0, n0, r0} : {s1, t1, b1, n1, r1};
    endfunction

    function automatic int div_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    // Expected outputs t cycles after the accept edge, from the timing rules.
    function automatic logic [4:0] model(input int t, input int sel,
                                         input logic [7:0] d);
        int nb, dv, idx;
        logic bv;
        nb = 8 + PB;
        dv = div_of(sel);
        if (t >= 1 && t <= nb * dv) begin
            idx = (t - 1) / dv;
            if (idx == 8)
                bv = ^d;
            else if (sel == 1)
                bv = d[7 - idx];
            else
                bv = d[idx];
            return {bv, ((t - 1) % dv) == 0, 1'b1, 1'b0, 1'b0};
        end
        if (t == nb * dv + 1)
            return 5'b00110;
        return 5'b00001;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            v0 = v;
            d0 = d;
        end else begin
            v1 = v;
            d1 = d;
        end
    endtask

    // Called just after a negedge with the instance idle; ends the same way.
    task automatic xfer(input string name, input int sel,
                        input logic [7:0] d, input bit hold);
        int last;
        logic [4:0] e;
        logic [4:0] o;
        last = (8 + PB) * div_of(sel) + 2;
        tests++;
        if (obs(sel) !== 5'b00001) begin
            fails++;
            $display("FAIL %s pre-accept got %b want 00001", name, obs(sel));
        end
        set_in(sel, 1'b1, d);
        @(posedge clk);
        #1;
        if (hold)
            set_in(sel, 1'b1, 8'($urandom));
        else
            set_in(sel, 1'b0, 8'h00);
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            e = model(t, sel, d);
            o = obs(sel);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s cycle k+%0d got %b want %b", name, t, o, e);
            end
            if (hold)
                set_in(sel, 1'b1, 8'($urandom));
        end
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        v0 = 1'b1;
        v1 = 1'b1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (obs(0) !== 5'b00001) begin
                fails++;
                $display("FAIL reset dut0 got %b want 00001", obs(0));
            end
            tests++;
            if (obs(1) !== 5'b00001) begin
                fails++;
                $display("FAIL reset dut1 got %b want 00001", obs(1));
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (obs(0) !== 5'b00001 || obs(1) !== 5'b00001) begin
            fails++;
            $display("FAIL reset_release got %b/%b want 00001", obs(0), obs(1));
        end
    endtask

    task automatic test_lsb_div4();
        xfer("lsb_a5", 0, 8'hA5, 1'b0);
    endtask

    task automatic test_msb_div1();
        xfer("msb_81", 1, 8'h81, 1'b0);
    endtask

    task automatic test_back_to_back();
        xfer("b2b_first", 0, 8'h5C, 1'b1);
        xfer("b2b_second", 0, 8'hE3, 1'b0);
        xfer("b2b_div1_a", 1, 8'h96, 1'b1);
        xfer("b2b_div1_b", 1, 8'h4B, 1'b0);
    endtask

    task automatic test_abort();
        logic [4:0] e;
        set_in(0, 1'b1, 8'hC6);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h00);
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            e = model(t, 0, 8'hC6);
            tests++;
            if (obs(0) !== e) begin
                fails++;
                $display("FAIL abort_pre cycle k+%0d got %b want %b", t, obs(0), e);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (obs(0) !== 5'b00001) begin
            fails++;
            $display("FAIL abort_async got %b want 00001", obs(0));
        end
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (obs(0) !== 5'b00001) begin
                fails++;
                $display("FAIL abort_hold got %b want 00001", obs(0));
            end
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            tests++;
            if (obs(0) !== 5'b00001) begin
                fails++;
                $display("FAIL abort_after got %b want 00001", obs(0));
            end
        end
        xfer("abort_fresh_3c", 0, 8'h3C, 1'b0);
    endtask

    task automatic test_parity();
        xfer("parity_07", 0, 8'h07, 1'b0);
        xfer("parity_div1_07", 1, 8'h07, 1'b0);
    endtask

    task automatic test_random();
        int sel;
        int gap;
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(negedge clk);
                tests++;
                if (obs(sel) !== 5'b00001) begin
                    fails++;
                    $display("FAIL rand_idle got %b want 00001", obs(sel));
                end
            end
            xfer("rand", sel, 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        d0 = 8'h00;
        d1 = 8'h00;
        test_reset();
        test_lsb_div4();
        test_msb_div1();
        test_back_to_back();
        test_abort();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
